// File: rtl/fsm_rx.sv
// rtl/fsm_rx.sv - UART receiver: 16x oversampling, 8N1 framing, Done/frame_err strobes
module fsm_rx #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       Done,
  output logic       frame_err,
  output logic       busy,
  output logic       tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state;
  logic           rx_m;
  logic           rx_s;
  logic           rx_p;
  logic [CW-1:0]  t_cnt;
  logic [3:0]     s_cnt;
  logic [2:0]     b_cnt;
  logic [7:0]     sh;
  logic           fall;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; all idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign fall = rx_p & ~rx_s;

  // Free-running oversample divider; tick marks its last count
  always_ff @(posedge clk) begin
    if (reset) begin
      t_cnt <= '0;
    end else if (t_cnt == TICK_LAST) begin
      t_cnt <= '0;
    end else begin
      t_cnt <= t_cnt + 1'b1;
    end
  end

  assign tick = (t_cnt == TICK_LAST);
  assign busy = (state != IDLE);

  // Receive FSM: start qualification at mid start bit, data/stop sampled every 16 ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= 4'd0;
      b_cnt     <= 3'd0;
      sh        <= 8'h00;
      dataout   <= 8'h00;
      Done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      Done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            s_cnt <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == 4'd7) begin
              s_cnt <= 4'd0;
              if (!rx_s) begin
                state <= DATA;
                b_cnt <= 3'd0;
              end else begin
                // Line went back high before mid-bit: a glitch, not a start bit
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              s_cnt <= 4'd0;
              sh    <= {rx_s, sh[7:1]};
              if (b_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                b_cnt <= b_cnt + 3'd1;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              // Return to IDLE at mid stop bit so a back-to-back start edge is caught
              s_cnt <= 4'd0;
              state <= IDLE;
              if (rx_s) begin
                dataout <= sh;
                Done    <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fsm_rx.md
# fsm_rx

UART receive state machine: the downstream partner of the transmit FSM. It oversamples the serial line at 16x the bit rate, detects and qualifies the start bit, and shifts in 8 data bits LSB-first. It then checks the stop bit and presents the received byte with a one-cycle `Done` strobe. Its `rx` input connects directly to the transmitter's serial output `x` in loopback builds.

## Interface
- `DIV`, default 4: `clk` cycles per oversample tick; one bit period = 16 × `DIV` clocks. Must be ≥ 2.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high; takes effect on the next `clk` rising edge.
- `rx` input 1: asynchronous serial line; idle high.
- `dataout` output 8: last correctly framed byte; bit 0 is the first data bit received.
- `Done` output 1: one-`clk` pulse when a valid frame completes.
- `frame_err` output 1: one-`clk` pulse when the stop bit samples low.
- `busy` output 1: high whenever state ≠ IDLE.
- `tick` output 1: oversample tick, high for one `clk` every `DIV` clocks.

## Operation
- Frame: 1 start bit (0), 8 data bits (LSB first), 1 stop bit (1). No parity.
- Synchronizer:
  - `rx` passes through two flops before use, giving `rx_s`.
  - Both flops reset to 1.
  - Falling-edge detect compares `rx_s` with its previous value; that value also resets to 1.
- Tick generator:
  - Free-running counter 0..`DIV`-1.
  - `tick` = 1 when the counter equals `DIV`-1.
  - Reset clears the counter to 0.
- Sample counter `s_cnt` (4 bits) advances only on `tick`.
- Bit counter `b_cnt` (3 bits) counts data bits.
- States:
  - IDLE: on a falling edge of `rx_s`, go to START with `s_cnt`=0.
  - START: on the tick where `s_cnt`=7 (mid start bit), check `rx_s`.
    - `rx_s`=0: go to DATA, with `s_cnt`=0 and `b_cnt`=0.
    - `rx_s`=1: treat as a glitch and return to IDLE with no output.
  - DATA: on the tick where `s_cnt`=15, sample `rx_s`.
    - Shift register: `sh <= {rx_s, sh[7:1]}`; then `s_cnt`=0.
    - If `b_cnt`=7, go to STOP; otherwise `b_cnt`++.
  - STOP: on the tick where `s_cnt`=15, sample `rx_s` and return to IDLE.
    - `rx_s`=1: load `dataout` from `sh` and pulse `Done`.
    - `rx_s`=0: pulse `frame_err`; `dataout` is unchanged.
- IDLE is re-entered at mid stop bit, so back-to-back frames with no idle gap are received.
- A line held low (break) yields `frame_err` once. No new frame starts until `rx_s` has gone high and then fallen again.
- Reset:
  - `dataout`=0x00, `Done`=0, `frame_err`=0, `busy`=0, `tick`=0.
  - State IDLE; `s_cnt`, `b_cnt` and `sh` cleared.
- Reset mid-frame abandons the frame silently: no `Done`, no `frame_err`.

## Timing
- `rx` to `rx_s`: 2 clk. Edge detection adds 1 clk.
- Start qualification happens 8 ticks after the detected edge, ±1 tick of phase uncertainty because the tick generator is free-running.
- Each data bit is sampled 16 ticks after the previous sample.
- `Done` or `frame_err` is registered on the same clk edge as the STOP→IDLE transition.
- `dataout` is valid from the `Done` cycle and holds until the next `Done` or reset.
- Frame latency from the start-bit falling edge on `rx` to `Done`: about 9.5 bit periods (≈ 608 clk at `DIV`=4), plus synchronizer delay.
- `Done` and `frame_err` are never high together, and never high for more than 1 clk.
- `busy` falls on the same edge that `Done` or `frame_err` rises.

## Test plan
- Nominal frame, `DIV`=4 (64 clk/bit), byte 0xB3 → `Done` pulses exactly once, 1 clk wide; `dataout`=0xB3; `frame_err` stays 0.
- Back-to-back frames 0xCC then 0x00 with no idle gap → two `Done` pulses ≈ 640 clk apart; `dataout` reads 0xCC, then 0x00.
- Glitch: `rx` low for 10 clk, then high → `busy` high briefly, then returns to IDLE; no `Done`, no `frame_err`; `dataout` unchanged.
- Framing error: frame 0x5A sent with stop bit 0 → `frame_err` pulses 1 clk; `Done` stays 0; `dataout` keeps its previous value.
- Reset mid-frame: `reset` asserted for 1 clk after 3 data bits of 0xFF → all outputs 0 the next clk, state IDLE; a following clean 0x5A frame gives `Done` with `dataout`=0x5A.
- Loopback: `rx` driven from the transmit FSM's `x`, sending 0xB3 then 0xCC → matching `dataout` values, one `Done` per frame, no `frame_err`.
